// File: rtl/jttms_vtimer_pkg.sv
// jttms_vtimer_pkg: register map and field positions for the video timer.
// Shared by the top and the per-axis counter.
package jttms_vtimer_pkg;

    localparam int DEF_CW = 12;
    localparam int NTREG  = 9;

    localparam logic [3:0] A_HS_END   = 4'd0;
    localparam logic [3:0] A_HB_END   = 4'd1;
    localparam logic [3:0] A_HB_START = 4'd2;
    localparam logic [3:0] A_H_TOTAL  = 4'd3;
    localparam logic [3:0] A_VS_END   = 4'd4;
    localparam logic [3:0] A_VB_END   = 4'd5;
    localparam logic [3:0] A_VB_START = 4'd6;
    localparam logic [3:0] A_V_TOTAL  = 4'd7;
    localparam logic [3:0] A_V_INT    = 4'd8;
    localparam logic [3:0] A_CTRL     = 4'd9;
    localparam logic [3:0] A_STATUS   = 4'd10;
    localparam logic [3:0] A_HCNT     = 4'd11;
    localparam logic [3:0] A_VCNT     = 4'd12;

    localparam int CTRL_EN = 0;
    localparam int CTRL_IE = 1;
    localparam int ST_INT  = 0;
    localparam int ST_LVBL = 1;

endpackage

// File: rtl/jttms_vtimer_axis.sv
// jttms_vtimer_axis: one timing axis (counter, wrap flag, sync/blank decode).
// Decodes are registered from the next count so they stay aligned with cnt.
module jttms_vtimer_axis
    import jttms_vtimer_pkg::*;
#(
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          step,
    input  logic [CW-1:0] total,
    input  logic [CW-1:0] sync_end,
    input  logic [CW-1:0] blank_end,
    input  logic [CW-1:0] blank_start,
    output logic [CW-1:0] cnt,
    output logic          wrap,
    output logic          sync,
    output logic          lbl
);

    logic [CW-1:0] cnt_nx;

    // A total below cnt never matches, so the count rolls over modulo 2^CW
    always_comb begin
        wrap   = en && step && (cnt == total);
        cnt_nx = cnt;
        if (!en)
            cnt_nx = '0;
        else if (wrap)
            cnt_nx = '0;
        else if (step)
            cnt_nx = cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            sync <= 1'b0;
            lbl  <= 1'b0;
        end else begin
            cnt  <= cnt_nx;
            sync <= cnt_nx < sync_end;
            lbl  <= (cnt_nx >= blank_end) && (cnt_nx < blank_start);
        end
    end

endmodule

// File: rtl/jttms_vtimer.sv
// jttms_vtimer: host-programmable video timing generator with line interrupt.
// Define JTTMS_VTIMER_SHADOW_EN to latch timing writes at the frame wrap.
module jttms_vtimer
    import jttms_vtimer_pkg::*;
#(
    parameter int            CW       = DEF_CW,
    parameter logic [CW-1:0] HS_END   = CW'('h010),
    parameter logic [CW-1:0] HB_END   = CW'('h020),
    parameter logic [CW-1:0] HB_START = CW'('h1f0),
    parameter logic [CW-1:0] H_TOTAL  = CW'('h1ff),
    parameter logic [CW-1:0] VS_END   = CW'('h004),
    parameter logic [CW-1:0] VB_END   = CW'('h010),
    parameter logic [CW-1:0] VB_START = CW'('h0f0),
    parameter logic [CW-1:0] V_TOTAL  = CW'('h0ff),
    parameter logic [CW-1:0] V_INT    = CW'('h000)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pxl_cen,
    input  logic [3:0]    addr,
    input  logic [15:0]   din,
    input  logic          wr,
    input  logic          rd,
    output logic [15:0]   dout,
    output logic [CW-1:0] hcnt,
    output logic [CW-1:0] vcnt,
    output logic          hs,
    output logic          vs,
    output logic          lhbl,
    output logic          lvbl,
    output logic          blank,
    output logic          int_n
);

    logic [CW-1:0] act [NTREG];
    logic          en, ie, int_q;
    logic          h_wrap, v_wrap;
    logic          h_sync, h_lbl, v_sync, v_lbl;
    logic [CW-1:0] v_nx;
    logic          wr_t, clr, set;
    logic [15:0]   rdata;

    function automatic logic [CW-1:0] rst_val(input int i);
        case (i)
            0:       rst_val = HS_END;
            1:       rst_val = HB_END;
            2:       rst_val = HB_START;
            3:       rst_val = H_TOTAL;
            4:       rst_val = VS_END;
            5:       rst_val = VB_END;
            6:       rst_val = VB_START;
            7:       rst_val = V_TOTAL;
            default: rst_val = V_INT;
        endcase
    endfunction

    generate
        if (CW < 16) begin : g_pad
            logic unused_din;
            assign unused_din = ^din[15:CW];
        end
    endgenerate

    assign wr_t = wr && (addr <= A_V_INT);

    jttms_vtimer_axis #(.CW(CW)) u_h (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .step        (pxl_cen),
        .total       (act[A_H_TOTAL]),
        .sync_end    (act[A_HS_END]),
        .blank_end   (act[A_HB_END]),
        .blank_start (act[A_HB_START]),
        .cnt         (hcnt),
        .wrap        (h_wrap),
        .sync        (h_sync),
        .lbl         (h_lbl)
    );

    jttms_vtimer_axis #(.CW(CW)) u_v (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .step        (h_wrap),
        .total       (act[A_V_TOTAL]),
        .sync_end    (act[A_VS_END]),
        .blank_end   (act[A_VB_END]),
        .blank_start (act[A_VB_START]),
        .cnt         (vcnt),
        .wrap        (v_wrap),
        .sync        (v_sync),
        .lbl         (v_lbl)
    );

    assign hs    = h_sync & en;
    assign lhbl  = h_lbl & en;
    assign vs    = v_sync & en;
    assign lvbl  = v_lbl & en;
    assign blank = ~(lhbl & lvbl);
    assign int_n = ~int_q;

    // Line the vertical counter lands on at this horizontal wrap
    assign v_nx = v_wrap ? '0 : vcnt + CW'(1);
    assign set  = h_wrap && ie && (v_nx == act[A_V_INT]);
    assign clr  = wr && (((addr == A_STATUS) && din[ST_INT]) ||
                         ((addr == A_CTRL) && !din[CTRL_IE]));

`ifdef JTTMS_VTIMER_SHADOW_EN
    logic [CW-1:0] shd [NTREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTREG; i++) shd[i] <= rst_val(i);
        end else if (wr_t) begin
            shd[addr] <= din[CW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTREG; i++) act[i] <= rst_val(i);
        end else if (v_wrap) begin
            for (int i = 0; i < NTREG; i++) act[i] <= shd[i];
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTREG; i++) act[i] <= rst_val(i);
        end else if (wr_t) begin
            act[addr] <= din[CW-1:0];
        end
    end
`endif

    always_comb begin
        rdata = '0;
        case (addr)
            A_CTRL:   rdata = 16'({ie, en});
            A_STATUS: rdata = 16'({lvbl, int_q});
            A_HCNT:   rdata = 16'(hcnt);
            A_VCNT:   rdata = 16'(vcnt);
            default: begin
                if (addr <= A_V_INT) begin
`ifdef JTTMS_VTIMER_SHADOW_EN
                    rdata = 16'(shd[addr]);
`else
                    rdata = 16'(act[addr]);
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en    <= 1'b0;
            ie    <= 1'b0;
            int_q <= 1'b0;
            dout  <= '0;
        end else begin
            if (wr && (addr == A_CTRL)) begin
                en <= din[CTRL_EN];
                ie <= din[CTRL_IE];
            end
            int_q <= set | (int_q & ~clr);
            if (rd && !wr)
                dout <= rdata;
        end
    end

endmodule
